// File: rtl/tlul_host_arb_pkg.sv
// Shared types for the two-host TL-UL arbiter: host identifiers and grant-lock state.
package tlul_host_arb_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic {
        HOST0 = 1'b0,
        HOST1 = 1'b1
    } host_id_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_H0   = 2'd1,
        LOCK_H1   = 2'd2
    } lock_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by hosts, devices and the arbiter.
// Field set follows the TL-UL A/D channel subset used in this slice.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA   = 3'h0;
    localparam logic [2:0] GET             = 3'h4;
    localparam logic [2:0] ACCESS_ACK      = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_id_fifo.sv
// 1-bit host-ID FIFO recording which host owns each outstanding A beat.
// Full blocks push even when a pop happens in the same cycle (no bypass).
module tlul_host_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            push_id,
    input  logic            pop,
    output logic            head_id,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Depth-1:0] mem_r;
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [CntW-1:0]  count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? {PtrW{1'b0}} : ptr + PtrW'(1);
    endfunction

    assign full      = (count_r == CntW'(Depth));
    assign empty     = (count_r == {CntW{1'b0}});
    assign count     = count_r;
    assign head_id   = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r    <= {Depth{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/tlul_host_arb_2to1.sv
// Two-host TL-UL arbiter: round-robin A-channel grant with lock while stalled,
// in-order D-channel routing via a host-ID FIFO. Payload fields pass through.
module tlul_host_arb_2to1
    import tlul_pkg::*;
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned Depth = DEFAULT_DEPTH,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h0_i,
    output tl_d2h_t         tl_h0_o,
    input  tl_h2d_t         tl_h1_i,
    output tl_d2h_t         tl_h1_o,
    output tl_h2d_t         tl_dev_o,
    input  tl_d2h_t         tl_dev_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_o
);

    host_id_e        rr_q;
    host_id_e        rr_d;
    lock_e           lock_q;
    lock_e           lock_d;
    logic            err_q;
    logic            err_d;

    host_id_e        sel_s;
    tl_h2d_t         sel_req_s;
    host_id_e        head_s;
    logic            head_bit_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CntW-1:0] fifo_count_s;
    logic            dev_a_valid_s;
    logic            dev_d_ready_s;
    logic            accept_s;
    logic            stall_s;
    logic            pop_s;
    logic            h0_d_valid_s;
    logic            h1_d_valid_s;

    // Grant selection: a lock always wins, then a lone requester, then round-robin.
    always_comb begin
        sel_s = rr_q;
        case (lock_q)
            LOCK_H0: sel_s = HOST0;
            LOCK_H1: sel_s = HOST1;
            LOCK_NONE: begin
                if (tl_h0_i.a_valid && !tl_h1_i.a_valid) begin
                    sel_s = HOST0;
                end else if (tl_h1_i.a_valid && !tl_h0_i.a_valid) begin
                    sel_s = HOST1;
                end else begin
                    sel_s = rr_q;
                end
            end
            default: sel_s = rr_q;
        endcase
    end

    assign sel_req_s     = (sel_s == HOST1) ? tl_h1_i : tl_h0_i;
    assign dev_a_valid_s = sel_req_s.a_valid && !fifo_full_s;
    assign accept_s      = dev_a_valid_s && tl_dev_i.a_ready;
    assign stall_s       = sel_req_s.a_valid && !accept_s;
    assign head_s        = host_id_e'(head_bit_s);

    // D-channel routing to the head-of-FIFO host; an empty FIFO drains and flags stray beats.
    always_comb begin
        dev_d_ready_s = 1'b1;
        h0_d_valid_s  = 1'b0;
        h1_d_valid_s  = 1'b0;
        err_d         = err_q;
        if (fifo_empty_s) begin
            err_d = err_q | tl_dev_i.d_valid;
        end else if (head_s == HOST1) begin
            h1_d_valid_s  = tl_dev_i.d_valid;
            dev_d_ready_s = tl_h1_i.d_ready;
        end else begin
            h0_d_valid_s  = tl_dev_i.d_valid;
            dev_d_ready_s = tl_h0_i.d_ready;
        end
    end

    assign pop_s = tl_dev_i.d_valid && dev_d_ready_s && !fifo_empty_s;

    // Output assembly: payloads pass through, handshake bits overridden.
    always_comb begin
        tl_dev_o         = sel_req_s;
        tl_dev_o.a_valid = dev_a_valid_s;
        tl_dev_o.d_ready = dev_d_ready_s;

        tl_h0_o          = tl_dev_i;
        tl_h0_o.a_ready  = (sel_s == HOST0) && tl_dev_i.a_ready && !fifo_full_s;
        tl_h0_o.d_valid  = h0_d_valid_s;

        tl_h1_o          = tl_dev_i;
        tl_h1_o.a_ready  = (sel_s == HOST1) && tl_dev_i.a_ready && !fifo_full_s;
        tl_h1_o.d_valid  = h1_d_valid_s;
    end

    // Arbitration next state: lock a stalled grant so A stays stable toward the device.
    always_comb begin
        rr_d   = rr_q;
        lock_d = LOCK_NONE;
        if (accept_s) begin
            rr_d   = (sel_s == HOST0) ? HOST1 : HOST0;
            lock_d = LOCK_NONE;
        end else if (stall_s) begin
            lock_d = (sel_s == HOST0) ? LOCK_H0 : LOCK_H1;
        end else begin
            lock_d = LOCK_NONE;
        end
    end

    // Arbitration and error state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= HOST0;
            lock_q <= LOCK_NONE;
            err_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    tlul_host_arb_id_fifo #(
        .Depth (Depth),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (accept_s),
        .push_id (sel_s == HOST1),
        .pop     (pop_s),
        .head_id (head_bit_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign outstanding_o = fifo_count_s;
    assign err_o         = err_q;

endmodule

// File: tb/tb_tlul_host_arb_2to1.sv
// Directed bench for tlul_host_arb_2to1: round-robin, grant lock, full FIFO,
// D back-pressure, stray-response error and mid-transaction reset.
module tb_tlul_host_arb_2to1;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h0_req;
    tl_h2d_t h1_req;
    tl_h2d_t dev_req;
    tl_d2h_t h0_rsp;
    tl_d2h_t h1_rsp;
    tl_d2h_t dev_rsp;
    logic [2:0] outstanding;
    logic    err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlul_host_arb_2to1 dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tl_h0_i       (h0_req),
        .tl_h0_o       (h0_rsp),
        .tl_h1_i       (h1_req),
        .tl_h1_o       (h1_rsp),
        .tl_dev_o      (dev_req),
        .tl_dev_i      (dev_rsp),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_data [4];
    int          exp_host [4];
    int          n0;
    int          n1;

    initial begin
        exp_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        exp_host = '{0, 1, 0, 1};
        h0_req = '0;
        h1_req = '0;
        dev_rsp = '0;
        h0_req.a_opcode = GET;
        h1_req.a_opcode = PUT_FULL_DATA;
        h0_req.a_mask = 4'hF;
        h1_req.a_mask = 4'hF;
        h1_req.a_source = 8'h01;
        dev_rsp.d_opcode = ACCESS_ACK_DATA;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        settle();
        check_val("rst_outstanding", outstanding, 32'd0);
        check_val("rst_err", err, 32'd0);
        check_val("rst_h0_d_valid", h0_rsp.d_valid, 32'd0);
        check_val("rst_h1_d_valid", h1_rsp.d_valid, 32'd0);
        check_val("rst_dev_d_ready", dev_req.d_ready, 32'd1);
        check_val("rst_dev_a_valid", dev_req.a_valid, 32'd0);

        // Round-robin with both hosts continuously valid, 1-cycle responses
        h0_req.d_ready = 1'b1;
        h1_req.d_ready = 1'b1;
        dev_rsp.a_ready = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            h0_req.a_valid = 1'b1;
            h0_req.a_data  = 32'hA0 + n0;
            h1_req.a_valid = 1'b1;
            h1_req.a_data  = 32'hB0 + n1;
            dev_rsp.d_valid = (k > 0);
            dev_rsp.d_data  = (k > 0) ? exp_data[(k > 0) ? k - 1 : 0] : 32'h0;
            settle();
            check_val("rr_a_data", dev_req.a_data, exp_data[k]);
            check_val("rr_h0_a_ready", h0_rsp.a_ready, exp_host[k] == 0);
            check_val("rr_h1_a_ready", h1_rsp.a_ready, exp_host[k] == 1);
            if (k > 0) begin
                check_val("rr_outstanding", outstanding, 32'd1);
                check_val("rr_h0_d_valid", h0_rsp.d_valid, exp_host[k-1] == 0);
                check_val("rr_h1_d_valid", h1_rsp.d_valid, exp_host[k-1] == 1);
                check_val("rr_d_data", (exp_host[k-1] == 0) ? h0_rsp.d_data : h1_rsp.d_data,
                          exp_data[k-1]);
            end
            tick();
            if (exp_host[k] == 0) n0++; else n1++;
        end
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b0;
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'hB1;
        settle();
        check_val("rr_last_h1_d_valid", h1_rsp.d_valid, 32'd1);
        check_val("rr_last_h0_d_valid", h0_rsp.d_valid, 32'd0);
        check_val("rr_idle_a_valid", dev_req.a_valid, 32'd0);
        tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("rr_drained", outstanding, 32'd0);

        // Grant lock: H1 stalled, H0 arrives and must wait
        dev_rsp.a_ready  = 1'b0;
        h1_req.a_valid   = 1'b1;
        h1_req.a_data    = 32'h11;
        h1_req.a_address = 32'h1100;
        settle();
        check_val("lock_a_valid", dev_req.a_valid, 32'd1);
        check_val("lock_c0_data", dev_req.a_data, 32'h11);
        check_val("lock_c0_h1_a_ready", h1_rsp.a_ready, 32'd0);
        tick();
        h0_req.a_valid   = 1'b1;
        h0_req.a_data    = 32'h22;
        h0_req.a_address = 32'h2200;
        for (int c = 1; c < 3; c++) begin
            settle();
            check_val("lock_stall_data", dev_req.a_data, 32'h11);
            check_val("lock_stall_addr", dev_req.a_address, 32'h1100);
            check_val("lock_stall_h0_a_ready", h0_rsp.a_ready, 32'd0);
            tick();
        end
        dev_rsp.a_ready = 1'b1;
        settle();
        check_val("lock_acc_h1_a_ready", h1_rsp.a_ready, 32'd1);
        check_val("lock_acc_h0_a_ready", h0_rsp.a_ready, 32'd0);
        check_val("lock_acc_data", dev_req.a_data, 32'h11);
        tick();
        h1_req.a_valid = 1'b0;
        settle();
        check_val("lock_next_data", dev_req.a_data, 32'h22);
        check_val("lock_next_h0_a_ready", h0_rsp.a_ready, 32'd1);
        tick();
        h0_req.a_valid = 1'b0;
        settle();
        check_val("lock_outstanding", outstanding, 32'd2);
        dev_rsp.d_valid = 1'b1;
        dev_rsp.d_data  = 32'h11;
        settle();
        check_val("lock_rsp1_h1", h1_rsp.d_valid, 32'd1);
        check_val("lock_rsp1_h0", h0_rsp.d_valid, 32'd0);
        tick();
        dev_rsp.d_data = 32'h22;
        settle();
        check_val("lock_rsp2_h0", h0_rsp.d_valid, 32'd1);
        check_val("lock_rsp2_data", h0_rsp.d_data, 32'h22);
        tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("lock_drained", outstanding, 32'd0);

        // Fill to Depth with no responses, then free one slot
        h0_req.a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h0_req.a_data = 32'h30 + i;
            settle();
            check_val("fill_a_ready", h0_rsp.a_ready, 32'd1);
            tick();
        end
        settle();
        check_val("full_outstanding", outstanding, 32'd4);
        check_val("full_dev_a_valid", dev_req.a_valid, 32'd0);
        check_val("full_h0_a_ready", h0_rsp.a_ready, 32'd0);
        check_val("full_h1_a_ready", h1_rsp.a_ready, 32'd0);
        dev_rsp.d_valid = 1'b1;
        settle();
        check_val("full_pop_h0_d_valid", h0_rsp.d_valid, 32'd1);
        check_val("full_no_bypass", h0_rsp.a_ready, 32'd0);
        check_val("full_no_bypass_dev", dev_req.a_valid, 32'd0);
        tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("full_after_pop", outstanding, 32'd3);
        check_val("full_reopen_a_ready", h0_rsp.a_ready, 32'd1);
        check_val("full_reopen_a_valid", dev_req.a_valid, 32'd1);
        tick();
        h0_req.a_valid = 1'b0;
        settle();
        check_val("full_refill", outstanding, 32'd4);
        dev_rsp.d_valid = 1'b1;
        repeat (4) tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("full_drained", outstanding, 32'd0);

        // D back-pressure from head host blocks the other host's response
        h0_req.a_valid = 1'b1;
        settle();
        tick();
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b1;
        settle();
        tick();
        h1_req.a_valid = 1'b0;
        h0_req.d_ready = 1'b0;
        dev_rsp.d_valid = 1'b1;
        settle();
        check_val("bp_dev_d_ready", dev_req.d_ready, 32'd0);
        check_val("bp_h0_d_valid", h0_rsp.d_valid, 32'd1);
        check_val("bp_h1_d_valid", h1_rsp.d_valid, 32'd0);
        tick();
        check_val("bp_no_pop", outstanding, 32'd2);
        h0_req.d_ready = 1'b1;
        settle();
        check_val("bp_release", dev_req.d_ready, 32'd1);
        tick();
        check_val("bp_h1_turn", h1_rsp.d_valid, 32'd1);
        check_val("bp_after_pop", outstanding, 32'd1);
        tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("bp_drained", outstanding, 32'd0);

        // Stray response with empty FIFO
        h0_req.d_ready = 1'b0;
        h1_req.d_ready = 1'b0;
        dev_rsp.d_valid = 1'b1;
        settle();
        check_val("err_dev_d_ready", dev_req.d_ready, 32'd1);
        check_val("err_h0_d_valid", h0_rsp.d_valid, 32'd0);
        check_val("err_h1_d_valid", h1_rsp.d_valid, 32'd0);
        check_val("err_before_edge", err, 32'd0);
        tick();
        dev_rsp.d_valid = 1'b0;
        settle();
        check_val("err_set", err, 32'd1);
        repeat (3) tick();
        check_val("err_sticky", err, 32'd1);

        // Reset with 3 outstanding and H1 locked
        h0_req.a_valid = 1'b1;
        h0_req.a_data  = 32'h50;
        repeat (3) tick();
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b1;
        dev_rsp.a_ready = 1'b0;
        settle();
        check_val("prerst_outstanding", outstanding, 32'd3);
        tick();
        rst = 1'b1;
        h1_req.a_valid = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        check_val("midrst_outstanding", outstanding, 32'd0);
        check_val("midrst_err", err, 32'd0);
        check_val("midrst_dev_d_ready", dev_req.d_ready, 32'd1);
        h0_req.a_valid = 1'b1;
        h0_req.a_data  = 32'h61;
        h1_req.a_valid = 1'b1;
        h1_req.a_data  = 32'h71;
        dev_rsp.a_ready = 1'b1;
        settle();
        check_val("postrst_grant_data", dev_req.a_data, 32'h61);
        check_val("postrst_h0_a_ready", h0_rsp.a_ready, 32'd1);
        check_val("postrst_h1_a_ready", h1_rsp.a_ready, 32'd0);
        tick();
        check_val("postrst_alternate", dev_req.a_data, 32'h71);
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlul_host_arb_2to1.md
# tlul_host_arb_2to1

Two-host TL-UL arbiter sharing one TL-UL device port, e.g. Ibex instruction and data adapters onto a single unified SRAM, or a debug/boot loader host alongside the core data port ahead of the DMEM/UART crossbar. Round-robin arbitration on the A channel with grant lock while a request is stalled. In-order response routing back to the originating host via an internal host-ID FIFO. Device A/D fields (address, data, source, opcode) pass through unmodified.

## Interface
- Depth, 4: max outstanding accepted A beats awaiting D response (≥1, power of two not required).
- CntW, $clog2(Depth+1): width of outstanding count.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- tl_h0_i  in  tl_h2d_t  host 0 request.
- tl_h0_o  out  tl_d2h_t  host 0 response.
- tl_h1_i  in  tl_h2d_t  host 1 request.
- tl_h1_o  out  tl_d2h_t  host 1 response.
- tl_dev_o  out  tl_h2d_t  device request.
- tl_dev_i  in  tl_d2h_t  device response.
- outstanding_o  out  CntW  current ID FIFO occupancy.
- err_o  out  1  sticky: device D beat seen with FIFO empty.

## Operation
- State: rr_q (preferred host, 0/1), lock_q {LOCK_NONE, LOCK_H0, LOCK_H1}, ID FIFO (1-bit host ID per entry), err_q.
- Selection: if lock_q=LOCK_Hx select Hx. Else if only one host a_valid select it; both valid select rr_q; none valid select rr_q (fields pass, a_valid=0).
- tl_dev_o = selected host h2d fields; tl_dev_o.a_valid = sel.a_valid && !full; d_ready driven per D rules below.
- Host a_ready: selected host gets tl_dev_i.a_ready && !full; non-selected host gets 0.
- Accept = tl_dev_o.a_valid && tl_dev_i.a_ready: push sel ID into FIFO; rr_q <= ~sel; lock_q <= LOCK_NONE.
- Stall = sel.a_valid && !accept (device not ready or full): lock_q <= LOCK_Hsel, guaranteeing TL-UL A stability toward the device.
- Lock never preempted; a locked host dropping a_valid (protocol violation) releases lock next cycle.
- Full: no push even if a pop occurs the same cycle (no bypass); device a_valid forced 0.
- D routing: head ID h. Host h gets tl_dev_i d-fields and d_valid; other host d_valid=0 (d-fields still driven, don't care). tl_dev_o.d_ready = host h d_ready. Pop on tl_dev_i.d_valid && d_ready.
- Empty FIFO: both host d_valid=0; tl_dev_o.d_ready=1 (drain); any tl_dev_i.d_valid sets err_q (cleared only by reset).
- Simultaneous push and pop (not full): occupancy unchanged, both take effect.
- Device responses assumed in order (single device or in-order xbar).
- Host a_ready/d_valid for the non-participating host is 0, never X.

## Timing
- A and D paths combinational: zero-cycle added latency; state updates at posedge clk_i.
- Reset (rst_i sampled high at edge): rr_q=0, lock_q=LOCK_NONE, FIFO empty, err_q=0 → outstanding_o=0, err_o=0, host d_valid=0, tl_dev_o.d_ready=1, tl_dev_o.a_valid follows h0/h1 valid per selection.
- Reset mid-transaction flushes FIFO; late device responses after reset set err_o (device expected to share reset).
- Throughput: one A accept per cycle; alternates H0/H1 when both continuously valid.
- Back-to-back: push at edge N visible as head at N+1 if FIFO was empty; response same cycle as request not possible.

## Structure
- Package tlul_host_arb_pkg: host_id_e (HOST0, HOST1), lock_e enum, default Depth constant.
- Sub-module tlul_host_arb_id_fifo: synchronous 1-bit-wide FIFO, Depth entries, push/pop/full/empty/count, synchronous active-high reset, no bypass.
- Top holds selection logic, rr/lock registers, err flag; uses tlul_pkg types.

## Test plan
- Both hosts valid every cycle, device a_ready=1, d returns 1 cycle later: accept order H0,H1,H0,H1; each host receives only its own responses (tag via a_data 0xA0+n / 0xB0+n).
- H1 valid, device a_ready=0 for 3 cycles, H0 raises valid cycle 1: H1 stays granted (lock_q=LOCK_H1), device a fields stable, H1 accepted cycle 3, H0 next.
- Depth=4, device never responds: 4 accepts, outstanding_o=4, a_ready=0 to both; one D beat with d_ready → outstanding_o=3, next accept following cycle, not same cycle.
- Host d_ready=0 for head host: tl_dev_o.d_ready=0, other host's pending response blocked, no pop until d_ready=1.
- Device d_valid with FIFO empty: tl_dev_o.d_ready=1, host d_valid=0, err_o=1 sticky until rst_i.
- rst_i asserted with 3 outstanding: next cycle outstanding_o=0, rr_q=0, lock released; first post-reset contention grants H0.
